// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port dmem between CPU and aux ports with round-robin,
// bounded aux bus lock and byte-enable write merging.
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            c_req,
  input  logic            c_we,
  input  logic [AW-1:0]   c_addr,
  input  logic [DW-1:0]   c_wdata,
  input  logic [DW/8-1:0] c_be,
  output logic [DW-1:0]   c_rdata,
  output logic            c_gnt,
  output logic            c_stall,
  input  logic            a_req,
  input  logic            a_we,
  input  logic [AW-1:0]   a_addr,
  input  logic [DW-1:0]   a_wdata,
  input  logic [DW/8-1:0] a_be,
  input  logic            a_lock,
  output logic [DW-1:0]   a_rdata,
  output logic            a_gnt,
  output logic            mem_we,
  output logic [AW-1:0]   mem_a,
  output logic [DW-1:0]   mem_wd,
  input  logic [DW-1:0]   mem_rd
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam int BW = DW / 8;
  logic          last_q, last_d, locked_q, locked_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] c_rdata_q, a_rdata_q, wdata, m;
  logic [BW-1:0] be;
  logic          sel_a, we, lock_hold;
  for (genvar b = 0; b < BW; b++) begin : g_m
    assign m[8*b +: 8] = {8{be[b]}};
  end
  always_comb begin
    lock_hold = locked_q & a_lock;
    sel_a     = a_req & (~c_req | (lock_hold ? (cnt_q < CW'(LOCK_MAX)) : ~last_q));
    c_gnt     = ~reset & c_req & ~sel_a;
    a_gnt     = ~reset & sel_a;
    c_stall   = c_req & ~c_gnt;
    we        = sel_a ? a_we : c_we;
    be        = sel_a ? a_be : c_be;
    wdata     = sel_a ? a_wdata : c_wdata;
    mem_a     = (sel_a ? a_addr : c_addr) & ~AW'(3);
    mem_we    = (c_gnt | a_gnt) & we & (|be);
    mem_wd    = (mem_rd & ~m) | (wdata & m);
    c_rdata   = c_gnt ? mem_rd : c_rdata_q;
    a_rdata   = a_gnt ? mem_rd : a_rdata_q;
    last_d    = a_gnt ? 1'b1 : c_gnt ? 1'b0 : last_q;
    locked_d  = locked_q;
    cnt_d     = cnt_q;
    if (!a_req) begin
      locked_d = 1'b0;
      cnt_d    = '0;
    end else if (a_gnt) begin
      locked_d = a_lock;
      cnt_d    = !a_lock ? '0 : (cnt_q == CW'(LOCK_MAX)) ? cnt_q : cnt_q + 1'b1;
    end else if (c_gnt && locked_q) begin
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q    <= 1'b1;
      locked_q  <= 1'b0;
      cnt_q     <= '0;
      c_rdata_q <= '0;
      a_rdata_q <= '0;
    end else begin
      last_q   <= last_d;
      locked_q <= locked_d;
      cnt_q    <= cnt_d;
      if (c_gnt) c_rdata_q <= mem_rd;
      if (a_gnt) a_rdata_q <= mem_rd;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a per-cycle reference model of grants,
// memory contents and read data, plus literal checks pinning key scenarios.
module tb_dmem_arbiter;
  localparam int LOCK_MAX = 8;
  logic        clk = 1'b0, reset;
  logic        c_req, c_we, c_gnt, c_stall;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic [3:0]  c_be;
  logic        a_req, a_we, a_lock, a_gnt;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_be;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic [31:0] dmem    [0:255] = '{default: 32'h0};
  logic [31:0] ref_mem [0:255] = '{default: 32'h0};
  int checks = 0, failures = 0;
  logic        m_last, m_locked;
  int          m_cnt;
  logic [31:0] m_cr, m_ar;

  dmem_arbiter #(.AW(32), .DW(32), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
    .c_rdata(c_rdata), .c_gnt(c_gnt), .c_stall(c_stall),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .a_lock(a_lock), .a_rdata(a_rdata), .a_gnt(a_gnt),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  assign mem_rd = dmem[mem_a[9:2]];
  always @(posedge clk) if (mem_we) dmem[mem_a[9:2]] <= mem_wd;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
    end
  endtask

  // Reference model: evaluated mid-cycle, when inputs are stable for the coming edge.
  always @(negedge clk) begin
    int w;
    logic [31:0] ea, wd, word, ew;
    logic [3:0]  be;
    logic        we, wr;
    if (reset) begin
      m_last = 1'b1; m_locked = 1'b0; m_cnt = 0; m_cr = '0; m_ar = '0;
      chk("rst_c_gnt", {31'b0, c_gnt}, 0);
      chk("rst_a_gnt", {31'b0, a_gnt}, 0);
      chk("rst_mem_we", {31'b0, mem_we}, 0);
      chk("rst_stall", {31'b0, c_stall}, {31'b0, c_req});
      chk("rst_c_rdata", c_rdata, 0);
      chk("rst_a_rdata", a_rdata, 0);
    end else begin
      w = 0;
      if (c_req && !a_req) w = 1;
      else if (a_req && !c_req) w = 2;
      else if (c_req && a_req) begin
        if (m_locked && a_lock) w = (m_cnt < LOCK_MAX) ? 2 : 1;
        else w = m_last ? 1 : 2;
      end
      chk("c_gnt", {31'b0, c_gnt}, {31'b0, w == 1});
      chk("a_gnt", {31'b0, a_gnt}, {31'b0, w == 2});
      chk("c_stall", {31'b0, c_stall}, {31'b0, c_req && w != 1});
      if (w != 0) begin
        ea   = ((w == 1) ? c_addr : a_addr) & ~32'h3;
        we   = (w == 1) ? c_we : a_we;
        be   = (w == 1) ? c_be : a_be;
        wd   = (w == 1) ? c_wdata : a_wdata;
        word = ref_mem[ea[9:2]];
        wr   = we && be != 4'h0;
        chk("mem_a", mem_a, ea);
        chk("mem_we", {31'b0, mem_we}, {31'b0, wr});
        if (wr) begin
          ew = word;
          for (int b = 0; b < 4; b++) if (be[b]) ew[8*b +: 8] = wd[8*b +: 8];
          chk("mem_wd", mem_wd, ew);
          ref_mem[ea[9:2]] = ew;
        end
        if (w == 1) m_cr = word; else m_ar = word;
        m_last = (w == 2);
      end else chk("mem_we_idle", {31'b0, mem_we}, 0);
      chk("c_rdata", c_rdata, m_cr);
      chk("a_rdata", a_rdata, m_ar);
      if (!a_req) begin
        m_locked = 1'b0; m_cnt = 0;
      end else if (w == 2) begin
        m_locked = a_lock;
        m_cnt = !a_lock ? 0 : (m_cnt < LOCK_MAX) ? m_cnt + 1 : m_cnt;
      end else if (w == 1 && m_locked) m_cnt = 0;
    end
  end

  task automatic nxt; @(posedge clk); #1; endtask
  task automatic smp; @(negedge clk); endtask

  initial begin
    reset = 1; c_req = 1; c_we = 0; c_addr = 0; c_wdata = 0; c_be = 0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; a_be = 0; a_lock = 0;
    smp; chk("L_rst_stall", {31'b0, c_stall}, 1); chk("L_rst_gnt", {31'b0, c_gnt}, 0);
    nxt; reset = 0; c_we = 1; c_addr = 32'h10; c_wdata = 32'hDEADBEEF; c_be = 4'hF;
    smp; chk("L_wr_gnt", {31'b0, c_gnt}, 1); chk("L_wr_stall", {31'b0, c_stall}, 0);
    chk("L_wr_we", {31'b0, mem_we}, 1);
    nxt; c_we = 0;
    smp; chk("L_rd_data", c_rdata, 32'hDEADBEEF); chk("L_rd_stall", {31'b0, c_stall}, 0);
    nxt; c_req = 0; a_req = 1; a_we = 1; a_addr = 32'h20; a_wdata = 32'h11223344; a_be = 4'hF;
    smp; chk("L_pre_gnt", {31'b0, a_gnt}, 1);
    nxt; a_req = 0; c_req = 1; c_we = 1; c_addr = 32'h20; c_wdata = 32'hAABBCCDD; c_be = 4'b0101;
    smp; nxt; c_we = 0;
    smp; chk("L_merge", c_rdata, 32'h11BB33DD);
    nxt; reset = 1;
    nxt; reset = 0; c_addr = 32'h10; a_req = 1; a_we = 0; a_addr = 32'h20; a_lock = 0;
    for (int i = 0; i < 6; i++) begin
      smp;
      chk("L_rr_c", {31'b0, c_gnt}, {31'b0, i % 2 == 0});
      chk("L_rr_stall", {31'b0, c_stall}, {31'b0, i % 2 == 1});
      nxt;
    end
    smp; chk("L_rr_ardata", a_rdata, 32'h11BB33DD);
    nxt; reset = 1;
    nxt; reset = 0; a_lock = 1;
    for (int i = 0; i < 19; i++) begin
      smp;
      chk("L_lock_c", {31'b0, c_gnt}, {31'b0, i % 9 == 0});
      chk("L_lock_a", {31'b0, a_gnt}, {31'b0, i % 9 != 0});
      nxt;
    end
    reset = 1; c_req = 0;
    nxt; reset = 0; a_we = 1; a_addr = 32'h40; a_be = 4'hF; a_wdata = 32'h1;
    smp; nxt; a_wdata = 32'h2;
    smp; nxt; a_wdata = 32'h3; reset = 1; c_req = 1; c_we = 0; c_addr = 32'h40;
    smp; chk("L_mid_agnt", {31'b0, a_gnt}, 0); chk("L_mid_cgnt", {31'b0, c_gnt}, 0);
    chk("L_mid_we", {31'b0, mem_we}, 0); chk("L_mid_stall", {31'b0, c_stall}, 1);
    nxt; reset = 0;
    smp; chk("L_mid_first", {31'b0, c_gnt}, 1); chk("L_mid_rd", c_rdata, 32'h2);
    nxt; c_req = 0; a_lock = 0; a_we = 1; a_addr = 32'h10; a_wdata = 32'h0; a_be = 4'h0;
    smp; chk("L_be0_gnt", {31'b0, a_gnt}, 1); chk("L_be0_we", {31'b0, mem_we}, 0);
    nxt; a_we = 0;
    smp; chk("L_be0_rd", a_rdata, 32'hDEADBEEF);
    nxt; a_req = 0;
    nxt; nxt;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
